// File: rtl/vend_sequencer.sv
// vend_sequencer: transaction controller for a multi-item vending machine.
// Accumulates coin credit, keeps a writable price table, checks selections
// against credit, then runs the dispenser handshake followed by one change
// handshake per remaining credit unit.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   coin_in           00 none, 01 one unit, 10 two units, 11 invalid coin
//   sel_valid/item    one-cycle selection strobe and item index
//   cancel            one-cycle refund request
//   cfg_we/item/price price-table write port, usable in any state
//   disp_req/item/ack dispenser handshake
//   chg_req/ack       change-hopper handshake, one unit per ack
//   credit            current credit (registered)
//   busy              high while dispensing or returning change
//   coin_reject       one-cycle pulse for a coin that was not accepted
//
// Optional build macro VEND_TIMEOUT_EN: adds an inactivity timer in COLLECT
// that forces a full refund after TIMEOUT_CYC quiet cycles.
module vend_sequencer #(
  parameter int NUM_ITEMS     = 4,
  parameter int PRICE_W       = 4,
  parameter int CREDIT_W      = 4,
  parameter int DEFAULT_PRICE = 3,
  parameter int TIMEOUT_CYC   = 1024,
  localparam int SEL_W        = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_item,
  input  logic [PRICE_W-1:0]  cfg_price,
  output logic                disp_req,
  output logic [SEL_W-1:0]    disp_item,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject
);

  localparam int CMP_W = (PRICE_W > CREDIT_W) ? PRICE_W : CREDIT_W;

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic [SEL_W-1:0]    disp_item_q, disp_item_d;
  logic                chg_req_q, chg_req_d;
  logic                busy_q, busy_d;
  logic                coin_reject_q, coin_reject_d;
  logic [PRICE_W-1:0]  price_q [NUM_ITEMS];
  logic [PRICE_W-1:0]  price_d [NUM_ITEMS];

  logic                coin_valid;
  logic [CREDIT_W:0]   coin_sum;
  logic [CMP_W-1:0]    credit_ext, price_ext;
  logic                activity;
  logic                timeout_hit;

  // 01 and 10 are the only coins with a value; 11 is a bad coin.
  assign coin_valid = coin_in[0] ^ coin_in[1];
  // Extra top bit of the sum flags a coin that would overflow the credit.
  assign coin_sum   = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_in};
  assign credit_ext = CMP_W'(credit_q);
  assign price_ext  = CMP_W'(price_q[sel_item]);
  assign activity   = (coin_in != 2'b00) || sel_valid;

`ifdef VEND_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1)) && !activity;

  // Counts quiet cycles spent in COLLECT; cleared by any coin or selection
  // and whenever COLLECT is entered or left.
  always_comb begin
    timer_d = '0;
    if (state_q == COLLECT && state_d == COLLECT && !activity)
      timer_d = timer_q + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    disp_item_d   = disp_item_q;
    coin_reject_d = (coin_in == 2'b11);
    price_d       = price_q;

    case (state_q)
      IDLE: begin
        if (coin_valid) begin
          if (coin_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_reject_d | coin_valid;
          state_d       = (credit_q != '0) ? CHANGE : IDLE;
        end else if (coin_valid) begin
          // A coin always wins over a same-cycle selection.
          if (coin_sum[CREDIT_W]) coin_reject_d = 1'b1;
          else                    credit_d      = coin_sum[CREDIT_W-1:0];
        end else if (timeout_hit) begin
          state_d = CHANGE;
        end else if (sel_valid && credit_ext >= price_ext) begin
          // Price is deducted here, so later table writes cannot touch it.
          credit_d    = CREDIT_W'(credit_ext - price_ext);
          disp_item_d = sel_item;
          disp_req_d  = 1'b1;
          state_d     = DISPENSE;
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_reject_d | coin_valid;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          state_d    = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_reject_d | coin_valid;
        if (chg_req_q && chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_d == '0) state_d = IDLE;
        end
      end
    endcase

    // Old price remains visible to a selection made in the same cycle.
    if (cfg_we) price_d[cfg_item] = cfg_price;

    chg_req_d = (state_d == CHANGE) && (credit_d != '0);
    busy_d    = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_item_q   <= '0;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) price_q[i] <= PRICE_W'(DEFAULT_PRICE);
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      disp_item_q   <= disp_item_d;
      chg_req_q     <= chg_req_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
      price_q       <= price_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_item   = disp_item_q;
  assign chg_req     = chg_req_q;
  assign credit      = credit_q;
  assign busy        = busy_q;
  assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Testbench for vend_sequencer: directed scenarios plus a randomized run,
// each cycle compared against a transaction-level reference model.
module tb_vend_sequencer;

`ifdef VEND_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 1024;
`endif

  localparam int P_IDLE = 0, P_COLLECT = 1, P_DISPENSE = 2, P_CHANGE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin_in = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'b00;
  logic       cancel = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_item = 2'b00;
  logic [3:0] cfg_price = 4'd0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack = 1'b0;
  logic       chg_req;
  logic       chg_ack = 1'b0;
  logic [3:0] credit;
  logic       busy;
  logic       coin_reject;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_phase;
  int         m_credit;
  int         m_idle;
  logic [1:0] m_item;
  logic       m_rej;
  int         m_price [4];

  vend_sequencer #(
    .NUM_ITEMS(4), .PRICE_W(4), .CREDIT_W(4), .DEFAULT_PRICE(3), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid), .sel_item(sel_item),
    .cancel(cancel), .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_price(cfg_price),
    .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit), .busy(busy),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {disp_req, disp_item, chg_req, busy, coin_reject, credit};
  endfunction

  function automatic logic [9:0] expv();
    logic [3:0] c;
    c = 4'(m_credit);
    return {m_phase == P_DISPENSE, m_item, m_phase == P_CHANGE,
            (m_phase == P_DISPENSE) || (m_phase == P_CHANGE), m_rej, c};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_idle = 0; m_item = 2'b00; m_rej = 1'b0;
    for (int i = 0; i < 4; i++) m_price[i] = 3;
  endtask

  // Applies one clock of the vending rules to the inputs presented at the edge.
  task automatic model_step();
    int  v;
    bit  valid;
    bit  act;
    v     = int'(coin_in);
    valid = (v == 1) || (v == 2);
    act   = (v != 0) || sel_valid;
    m_rej = (v == 3);
    case (m_phase)
      P_IDLE: if (valid) begin m_credit += v; m_phase = P_COLLECT; m_idle = 0; end
      P_COLLECT: begin
        if (cancel) begin
          if (valid) m_rej = 1'b1;
          m_phase = P_CHANGE;
        end else if (valid) begin
          if (m_credit + v > 15) m_rej = 1'b1;
          else m_credit += v;
        end else if (sel_valid && m_credit >= m_price[sel_item]) begin
          m_credit -= m_price[sel_item];
          m_item = sel_item;
          m_phase = P_DISPENSE;
        end
`ifdef VEND_TIMEOUT_EN
        if (m_phase == P_COLLECT) begin
          if (act) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == TCYC) m_phase = P_CHANGE;
          end
        end
`else
        if (act) m_idle = 0;
`endif
      end
      P_DISPENSE: begin
        if (valid) m_rej = 1'b1;
        if (disp_ack) m_phase = (m_credit > 0) ? P_CHANGE : P_IDLE;
      end
      default: begin
        if (valid) m_rej = 1'b1;
        if (chg_ack) begin
          m_credit--;
          if (m_credit == 0) m_phase = P_IDLE;
        end
      end
    endcase
    if (cfg_we) m_price[cfg_item] = int'(cfg_price);
  endtask

  // One clock: model sees the same inputs as the DUT, then strobes are cleared.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    coin_in = 2'b00; sel_valid = 1'b0; cancel = 1'b0; cfg_we = 1'b0;
    disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 10'd0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs(), 10'd0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", obs(), expv());
    end
  endtask

  task automatic test_purchase();
    coin_in = 2'b01; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL purchase_coin1: got %b expected %b", obs(), expv()); end
    coin_in = 2'b10; tick();
    checks++;
    if (credit !== 4'd3) begin errors++; $display("FAIL purchase_credit3: got %0d expected 3", credit); end
    sel_valid = 1'b1; sel_item = 2'd0; tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL purchase_disp c%0d: got %b expected %b", i, obs(), expv()); end
      tick();
    end
    disp_ack = 1'b1; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL purchase_done: got %b expected %b", obs(), expv()); end
    tick();
    checks++;
    if (chg_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL purchase_nochg: got chg_req=%b busy=%b expected 0 0", chg_req, busy);
    end
  endtask

  task automatic test_change();
    coin_in = 2'b10; tick();
    coin_in = 2'b10; tick();
    sel_valid = 1'b1; sel_item = 2'd1; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL change_sel: got %b expected %b", obs(), expv()); end
    disp_ack = 1'b1; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL change_req: got %b expected %b", obs(), expv()); end
    chg_ack = 1'b1; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL change_done: got %b expected %b", obs(), expv()); end
  endtask

  task automatic test_cfg_cancel();
    cfg_we = 1'b1; cfg_item = 2'd2; cfg_price = 4'd6; tick();
    coin_in = 2'b10; tick();
    coin_in = 2'b10; tick();
    sel_valid = 1'b1; sel_item = 2'd2; tick();
    checks++;
    if (credit !== 4'd4 || disp_req !== 1'b0) begin
      errors++; $display("FAIL cfg_sel_ignored: got credit=%0d disp_req=%b expected 4 0", credit, disp_req);
    end
    cancel = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL cancel_hold c%0d: got %b expected %b", i, obs(), expv()); end
    end
    for (int i = 0; i < 4; i++) begin
      chg_ack = 1'b1; tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL cancel_refund c%0d: got %b expected %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin coin_in = 2'b10; tick(); end
    coin_in = 2'b10; sel_valid = 1'b1; sel_item = 2'd0; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL coin_and_sel: got %b expected %b", obs(), expv()); end
    coin_in = 2'b10; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL overflow_reject: got %b expected %b", obs(), expv()); end
    coin_in = 2'b01; tick();
    checks++;
    if (credit !== 4'd15) begin errors++; $display("FAIL credit_max: got %0d expected 15", credit); end
    coin_in = 2'b11; tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL bad_coin: got %b expected %b", obs(), expv()); end
    cancel = 1'b1; tick();
    for (int n = 0; n < 20 && m_phase != P_IDLE; n++) begin chg_ack = 1'b1; tick(); end
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL overflow_drain: got %b expected %b", obs(), expv()); end
  endtask

  task automatic test_reset_mid();
    coin_in = 2'b10; tick();
    coin_in = 2'b10; tick();
    coin_in = 2'b01; tick();
    sel_valid = 1'b1; sel_item = 2'd0; tick();
    checks++;
    if (disp_req !== 1'b1 || credit !== 4'd2) begin
      errors++; $display("FAIL mid_setup: got disp_req=%b credit=%0d expected 1 2", disp_req, credit);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 10'd0) begin errors++; $display("FAIL reset_async: got %b expected %b", obs(), 10'd0); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL reset_release: got %b expected %b", obs(), expv()); end
  endtask

  task automatic test_timeout();
    coin_in = 2'b10; tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL timeout_pre: got %b expected %b", obs(), expv()); end
    tick();
`ifdef VEND_TIMEOUT_EN
    checks++;
    if (chg_req !== 1'b1 || credit !== 4'd2) begin
      errors++; $display("FAIL timeout_fire: got chg_req=%b credit=%0d expected 1 2", chg_req, credit);
    end
`endif
    for (int i = 0; i < 84; i++) tick();
`ifndef VEND_TIMEOUT_EN
    checks++;
    if (credit !== 4'd2 || chg_req !== 1'b0) begin
      errors++; $display("FAIL no_timeout: got credit=%0d chg_req=%b expected 2 0", credit, chg_req);
    end
    cancel = 1'b1; tick();
`endif
    for (int n = 0; n < 10 && m_phase != P_IDLE; n++) begin chg_ack = 1'b1; tick(); end
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL timeout_drain: got %b expected %b", obs(), expv()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      coin_in   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) coin_in = 2'b00;
      sel_valid = ($urandom_range(0, 4) == 0);
      sel_item  = 2'($urandom_range(0, 3));
      cancel    = ($urandom_range(0, 19) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_item  = 2'($urandom_range(0, 3));
      cfg_price = 4'($urandom_range(0, 7));
      disp_ack  = $urandom_range(0, 1) == 1;
      chg_ack   = $urandom_range(0, 1) == 1;
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random c%0d: got %b expected %b", i, obs(), expv()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_purchase();
    test_change();
    test_cfg_cancel();
    test_overflow();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
